// File: rtl/coax_pkg.sv
// Shared constants and receiver state encoding for the 3270 coax link.
// Timing constants are in 18.869 MHz clock cycles.
package coax_pkg;

  localparam int CLOCKS_PER_BIT = 8;
  localparam int WINDOW         = 2;
  localparam int QUIESCE_BITS   = 5;
  localparam int CV_CLOCKS      = 12;
  localparam int END_CLOCKS     = 2 * CLOCKS_PER_BIT;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_QUIESCE,
    RX_CV_HIGH,
    RX_CV_LOW,
    RX_SYNC,
    RX_DATA,
    RX_PARITY,
    RX_END
  } rx_state_t;

endpackage

// File: rtl/coax_rx_bit_timer.sv
// Synchronizer, edge detector and digital PLL that recovers biphase mid-bit
// transitions. All outputs are registered and mutually aligned.
module coax_rx_bit_timer
  import coax_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic hunt,
  output logic rx_bit,
  output logic bit_valid,
  output logic timeout,
  output logic rx_edge,
  output logic rx_sync
);

  localparam logic [3:0] WIN_LO = 4'(CLOCKS_PER_BIT - WINDOW);
  localparam logic [3:0] WIN_HI = 4'(CLOCKS_PER_BIT + WINDOW);

  logic       meta;
  logic       sync;
  logic       last;
  logic [3:0] cnt;
  logic       raw_edge;
  logic       rising;
  logic       in_window;
  logic       accept;

  // cnt is the offset of the current edge from the last accepted mid-bit edge;
  // it parks at WIN_HI+1 after a timeout so only a hunt can relock it.
  assign raw_edge  = sync ^ last;
  assign rising    = sync & ~last;
  assign in_window = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign accept    = hunt ? rising : (raw_edge && in_window);
  assign rx_sync   = last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      last      <= 1'b0;
      cnt       <= WIN_HI + 4'd1;
      rx_bit    <= 1'b0;
      bit_valid <= 1'b0;
      timeout   <= 1'b0;
      rx_edge   <= 1'b0;
    end else begin
      meta      <= rx;
      sync      <= meta;
      last      <= sync;
      rx_edge   <= raw_edge;
      bit_valid <= accept;
      timeout   <= !accept && (cnt == WIN_HI);
      if (accept) begin
        rx_bit <= sync;
        cnt    <= 4'd1;
      end else if (cnt <= WIN_HI) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/coax_rx.sv
// 3270 coax receiver: start-sequence detection, 10-bit word deframing and
// parity/mid-bit error reporting on top of the recovered bit stream.
module coax_rx
  import coax_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       active,
  output logic [9:0] data,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       loss_of_midbit
);

  localparam logic [3:0] ONES_MIN = 4'(QUIESCE_BITS);
  localparam logic [3:0] CV_LO    = 4'(CV_CLOCKS - WINDOW);
  localparam logic [3:0] CV_HI    = 4'(CV_CLOCKS + WINDOW);
  localparam logic [3:0] CV_START = 4'(CLOCKS_PER_BIT + WINDOW + 1);
  localparam logic [4:0] END_LAST = 5'(END_CLOCKS - 1);

  rx_state_t  state;
  rx_state_t  next_state;
  logic       rx_bit, bit_valid, timeout, rx_edge, rx_sync, hunt;
  logic [3:0] ones_count, cv_cnt, bit_index;
  logic [4:0] end_cnt;
  logic [9:0] shreg;
  logic       cv_in_window, cv_late;
  logic       active_next, strobe_next, perr_next, loss_next;

  assign hunt = (state == RX_IDLE) || (state == RX_CV_LOW);

  coax_rx_bit_timer u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .hunt      (hunt),
    .rx_bit    (rx_bit),
    .bit_valid (bit_valid),
    .timeout   (timeout),
    .rx_edge   (rx_edge),
    .rx_sync   (rx_sync)
  );

  // cv_cnt tracks the offset of the edge seen this cycle from the last
  // mid-bit edge (CV_HIGH) or from the falling CV edge (CV_LOW).
  assign cv_in_window = (cv_cnt >= CV_LO) && (cv_cnt <= CV_HI);
  assign cv_late      = cv_cnt > CV_HI;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      ones_count <= 4'd0;
      cv_cnt     <= 4'd0;
      bit_index  <= 4'd0;
      end_cnt    <= 5'd0;
      shreg      <= 10'd0;
    end else begin
      state <= next_state;
      if (state == RX_IDLE) ones_count <= 4'd1;
      else if (state == RX_QUIESCE && bit_valid && rx_bit && ones_count != 4'hf)
        ones_count <= ones_count + 4'd1;
      if (state == RX_QUIESCE) cv_cnt <= CV_START;
      else if (state == RX_CV_HIGH && rx_edge) cv_cnt <= 4'd1;
      else if (cv_cnt != 4'hf) cv_cnt <= cv_cnt + 4'd1;
      if (state != RX_DATA) bit_index <= 4'd9;
      else if (bit_valid) bit_index <= bit_index - 4'd1;
      if (state == RX_DATA && bit_valid) shreg <= {shreg[8:0], rx_bit};
      end_cnt <= (state == RX_END) ? end_cnt + 5'd1 : 5'd0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:
        if (rx_edge && rx_sync) next_state = RX_QUIESCE;
      RX_QUIESCE:
        if (bit_valid && !rx_bit) next_state = RX_IDLE;
        else if (timeout)
          next_state = (ones_count >= ONES_MIN && rx_sync) ? RX_CV_HIGH : RX_IDLE;
      RX_CV_HIGH:
        if (rx_edge) next_state = cv_in_window ? RX_CV_LOW : RX_IDLE;
        else if (cv_late) next_state = RX_IDLE;
      RX_CV_LOW:
        if (rx_edge) next_state = (cv_in_window && rx_sync) ? RX_DATA : RX_IDLE;
        else if (cv_late) next_state = RX_IDLE;
      RX_SYNC:
        if (timeout) next_state = RX_IDLE;
        else if (bit_valid) next_state = rx_bit ? RX_DATA : RX_END;
      RX_DATA:
        if (timeout) next_state = RX_IDLE;
        else if (bit_valid && bit_index == 4'd0) next_state = RX_PARITY;
      RX_PARITY:
        if (timeout) next_state = RX_IDLE;
        else if (bit_valid) next_state = RX_SYNC;
      RX_END:
        if (rx_edge || end_cnt == END_LAST) next_state = RX_IDLE;
      default:
        next_state = RX_IDLE;
    endcase
  end

  // data_strobe is a one-cycle valid with no back-pressure; data holds
  // its value until the next strobe.
  always_comb begin
    active_next = next_state inside {RX_SYNC, RX_DATA, RX_PARITY, RX_END};
    strobe_next = (state == RX_PARITY) && bit_valid;
    perr_next   = strobe_next && (^{shreg, rx_bit});
    loss_next   = (state inside {RX_SYNC, RX_DATA, RX_PARITY}) && timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active         <= 1'b0;
      data           <= 10'd0;
      data_strobe    <= 1'b0;
      parity_error   <= 1'b0;
      loss_of_midbit <= 1'b0;
    end else begin
      active         <= active_next;
      data_strobe    <= strobe_next;
      parity_error   <= perr_next;
      loss_of_midbit <= loss_next;
      if (strobe_next) data <= shreg;
    end
  end

endmodule
